// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the ALU control decoder and the multiply/divide engine.
// The decoder drives the master side; the engine sits on the slave side.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             multOp;
    logic             divOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divZero;

    modport master (
        output multOp, divOp, A, B,
        input  hi, lo, busy, done, divZero
    );

    modport slave (
        input  multOp, divOp, A, B,
        output hi, lo, busy, done, divZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) engine
// owning the architectural hi/lo registers; one iteration per clock, busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateType;

    stateType stateReg, stateNext;

    logic             multPrev, divPrev;
    logic             multStart, divStart;
    logic [CW-1:0]    count;
    logic             lastStep;

    logic [WIDTH-1:0] hiReg, loReg;
    logic             busyReg, doneReg, divZeroReg;

    logic [WIDTH:0]   mcand, acc, accSum, accNext;
    logic [WIDTH-1:0] mq, mqNext;
    logic             qm1, qm1Next;

    logic [WIDTH-1:0] dvs, rem, quo, remNext, quoNext;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic             negQuo, negRem, zeroPend;
    logic [WIDTH-1:0] absA, absB;

    assign multStart = bus.multOp & ~multPrev;
    assign divStart  = bus.divOp  & ~divPrev;
    assign lastStep  = (count == CW'(1));

    assign absA = bus.A[WIDTH-1] ? (~bus.A + WIDTH'(1)) : bus.A;
    assign absB = bus.B[WIDTH-1] ? (~bus.B + WIDTH'(1)) : bus.B;

    assign bus.hi      = hiReg;
    assign bus.lo      = loReg;
    assign bus.busy    = busyReg;
    assign bus.done    = doneReg;
    assign bus.divZero = divZeroReg;

    always_ff @(posedge clk) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (divStart)       stateNext = DIV;
                else if (multStart) stateNext = MULT;
            end
            MULT:    if (lastStep) stateNext = DONE;
            DIV:     if (zeroPend || lastStep) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Booth step: the accumulator carries one extra bit so subtracting -2^(W-1) cannot overflow.
    always_comb begin
        case ({mq[0], qm1})
            2'b01:   accSum = acc + mcand;
            2'b10:   accSum = acc - mcand;
            default: accSum = acc;
        endcase
        accNext = {accSum[WIDTH], accSum[WIDTH:1]};
        mqNext  = {accSum[0], mq[WIDTH-1:1]};
        qm1Next = mq[0];
    end

    // Restoring step; when the trial fits, the true difference is below the divisor so W bits suffice.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs});
        remNext = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
        quoNext = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg      <= '0;
            loReg      <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
            multPrev   <= 1'b0;
            divPrev    <= 1'b0;
            count      <= '0;
            zeroPend   <= 1'b0;
        end else begin
            multPrev <= bus.multOp;
            divPrev  <= bus.divOp;
            busyReg  <= (stateNext != IDLE);
            doneReg  <= (stateNext == DONE);
            case (stateReg)
                IDLE: begin
                    if (divStart) begin
                        divZeroReg <= 1'b0;
                        count      <= CW'(WIDTH);
                        dvs        <= absB;
                        quo        <= absA;
                        rem        <= '0;
                        negQuo     <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        negRem     <= bus.A[WIDTH-1];
                        zeroPend   <= (bus.B == '0);
                    end else if (multStart) begin
                        divZeroReg <= 1'b0;
                        count      <= CW'(WIDTH);
                        mcand      <= {bus.A[WIDTH-1], bus.A};
                        acc        <= '0;
                        mq         <= bus.B;
                        qm1        <= 1'b0;
                    end
                end
                MULT: begin
                    acc   <= accNext;
                    mq    <= mqNext;
                    qm1   <= qm1Next;
                    count <= count - CW'(1);
                    if (lastStep) begin
                        hiReg <= accNext[WIDTH-1:0];
                        loReg <= mqNext;
                    end
                end
                DIV: begin
                    // A zero divisor skips the iterations and leaves hi/lo untouched.
                    if (zeroPend) begin
                        divZeroReg <= 1'b1;
                        zeroPend   <= 1'b0;
                    end else begin
                        rem   <= remNext;
                        quo   <= quoNext;
                        count <= count - CW'(1);
                        if (lastStep) begin
                            loReg <= negQuo ? (~quoNext + WIDTH'(1)) : quoNext;
                            hiReg <= negRem ? (~remNext + WIDTH'(1)) : remNext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products, quotients, latencies and
// handshake corner cases, checked with immediate assertions.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A      = a;
        bus.B      = b;
        bus.multOp = m;
        bus.divOp  = d;
    endtask

    // Counts negedges since the accept edge until done is seen; -1 means the bound expired.
    task automatic waitDone(input string tag, input int startCyc, output int cyc);
        logic found;
        found = 1'b0;
        cyc   = startCyc;
        while (cyc < 120 && !found) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) checkOutput({tag, ".busyEarly"}, {31'b0, bus.busy}, 32'd1);
            if (bus.done === 1'b1) found = 1'b1;
        end
        if (!found) cyc = -1;
    endtask

    task automatic runOp(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input int expCyc,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz);
        int cyc;
        applyStimulus(m, d, a, b);
        waitDone(tag, 0, cyc);
        checkOutput({tag, ".cycles"}, 32'(cyc), 32'(expCyc));
        checkOutput({tag, ".hi"}, bus.hi, expHi);
        checkOutput({tag, ".lo"}, bus.lo, expLo);
        checkOutput({tag, ".divZero"}, {31'b0, bus.divZero}, {31'b0, expDz});
        checkOutput({tag, ".busyAtDone"}, {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        checkOutput({tag, ".doneDrop"}, {31'b0, bus.done}, 32'd0);
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int doneCount;
        reset      = 1'b1;
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.hi", bus.hi, 32'h0);
        checkOutput("reset.lo", bus.lo, 32'h0);
        checkOutput("reset.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset.done", {31'b0, bus.done}, 32'd0);
        checkOutput("reset.divZero", {31'b0, bus.divZero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        runOp("mul7x6", 1, 0, 32'd7, 32'd6, 33, 32'h0, 32'd42, 1'b0);
        runOp("mulMinSq", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 1'b0);
        runOp("mulNeg3x5", 1, 0, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        runOp("div7byNeg2", 0, 1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        runOp("divNeg7by2", 0, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("divMinByNeg1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);

        runOp("pre3x4", 1, 0, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0);
        runOp("div9by0", 0, 1, 32'd9, 32'd0, 2, 32'h0, 32'd12, 1'b1);

        $display("[TB] mult after divide-by-zero clears the flag at accept");
        applyStimulus(1, 0, 32'd2, 32'd3);
        @(negedge clk);
        checkOutput("dzClear.divZero", {31'b0, bus.divZero}, 32'd0);
        waitDone("dzClear", 1, cyc);
        checkOutput("dzClear.cycles", 32'(cyc), 32'd33);
        checkOutput("dzClear.lo", bus.lo, 32'd6);
        bus.multOp = 1'b0;
        @(negedge clk);

        $display("[TB] hold multOp for 100 cycles");
        applyStimulus(1, 0, 32'd5, 32'd5);
        doneCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("hold.doneCount", 32'(doneCount), 32'd1);
        checkOutput("hold.lo", bus.lo, 32'd25);
        bus.multOp = 1'b0;
        @(negedge clk);

        $display("[TB] divOp rises mid-multiply");
        applyStimulus(1, 0, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        bus.divOp = 1'b1;
        waitDone("midDiv", 10, cyc);
        checkOutput("midDiv.cycles", 32'(cyc), 32'd33);
        checkOutput("midDiv.hi", bus.hi, 32'h0);
        checkOutput("midDiv.lo", bus.lo, 32'd81);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("midDiv.noRetrigger", 32'(doneCount), 32'd0);
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        @(negedge clk);

        runOp("bothOps", 1, 1, 32'd20, 32'd3, 33, 32'd2, 32'd6, 1'b0);

        $display("[TB] operands change during a multiply");
        applyStimulus(1, 0, 32'd11, 32'd13);
        repeat (5) @(negedge clk);
        bus.A = 32'd1000;
        bus.B = 32'hFFFF_0000;
        waitDone("lateAB", 5, cyc);
        checkOutput("lateAB.cycles", 32'(cyc), 32'd33);
        checkOutput("lateAB.hi", bus.hi, 32'h0);
        checkOutput("lateAB.lo", bus.lo, 32'd143);
        bus.multOp = 1'b0;
        @(negedge clk);

        $display("[TB] reset during divide iteration 10");
        applyStimulus(0, 1, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset      = 1'b1;
        bus.divOp  = 1'b0;
        @(negedge clk);
        checkOutput("midReset.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midReset.done", {31'b0, bus.done}, 32'd0);
        checkOutput("midReset.hi", bus.hi, 32'h0);
        checkOutput("midReset.lo", bus.lo, 32'h0);
        checkOutput("midReset.divZero", {31'b0, bus.divZero}, 32'd0);
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("midReset.noDone", 32'(doneCount), 32'd0);

        runOp("afterReset6x7", 1, 0, 32'd6, 32'd7, 33, 32'h0, 32'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide engine that answers the multOp/divOp requests issued by the ALU control decoder.
- Owns the architectural hi/lo registers that the datapath reads through the hi/lo source-mux selections.
- Multiply is radix-2 Booth; divide is restoring on magnitudes with sign fix-up. One iteration per clock.
- Reports completion with a busy/done handshake so the control FSM can hold its state until done.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
multOp  input  1  multiply request (level, from ALU control decoder)
divOp  input  1  divide request (level, from ALU control decoder)
A  input  WIDTH  operand X / dividend, signed two's complement
B  input  WIDTH  operand Y / divisor, signed two's complement
hi  output  WIDTH  mult: upper product half; div: remainder
lo  output  WIDTH  mult: lower product half; div: quotient
busy  output  1  high while an operation is in progress (states MULT, DIV, DONE)
done  output  1  one-cycle pulse: hi/lo hold the new result
divZero  output  1  last accepted divide had B == 0; held until the next accept

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset takes priority over everything, including mid-operation. It aborts any in-flight operation, goes to IDLE, and sets hi=0, lo=0, busy=0, done=0, divZero=0 and the edge-detect registers to 0.
- States: IDLE, MULT, DIV, DONE.
- Request detection is a rising edge: per-op registered previous level. Start = op high now and low last cycle. The decoder holds the op level for many cycles, so a held level never retriggers.
- Accept happens only in IDLE. If both starts occur in the same cycle, divOp wins.
- Starts seen outside IDLE are dropped and never queued. The previous-level registers update every cycle regardless of state.
- Accept edge (edge 0):
  - A and B are sampled; later changes are ignored.
  - divZero clears.
  - Iteration counter loads WIDTH.
- MULT:
  - Booth step on {acc, multiplier, q-1}: add/sub multiplicand by bit pair, then arithmetic shift right.
  - The counter decrements each edge.
  - On edge WIDTH the product is written: hi=product[2W-1:W], lo=product[W-1:0]; state goes to DONE.
- DIV, normal path:
  - |A| and |B| are taken as unsigned; |-2^(W-1)| = 2^(W-1).
  - WIDTH restoring steps, one per edge.
  - On edge WIDTH: lo = quotient, negated if the signs of A and B differ; hi = remainder, negated if A < 0.
  - Net effect: truncation toward zero, and the remainder takes the dividend's sign.
- DIV, overflow case: -2^(W-1) / -1 gives lo = 0x80000000, hi = 0 (wraps, no flag).
- DIV, divide-by-zero: if B == 0 at accept, no iterations run. The next edge goes to DONE with divZero=1, and hi/lo are unchanged.
- DONE: lasts exactly one cycle with done=1 and busy=1, then returns to IDLE.
- Latency: for mult/div, done is high in the cycle after edge WIDTH, i.e. between edges 32 and 33. For div-by-zero, done is high between edges 1 and 2.
- A new start can be accepted in the first IDLE cycle after DONE.
- hi/lo change only on a result-write edge or on reset. They are never touched by intermediate iterations, which use internal registers.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then A=7, B=6, rise multOp → busy on edge 1; done pulse 33 cycles after accept; hi=0, lo=42; done low again the next cycle.
- Signed multiply extremes: A=B=0x80000000 → hi=0x40000000, lo=0. A=-3 (0xFFFFFFFD), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divide signs:
  - 7/-2 → lo=0xFFFFFFFD, hi=1.
  - -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/-1 → lo=0x80000000, hi=0.
  - Check each done at 33 cycles.
- Divide by zero: preload hi/lo via 3*4 (hi=0, lo=12), then 9/0 → done 2 cycles after accept, divZero=1, hi=0, lo=12. A following mult accept clears divZero.
- Handshake abuse:
  - Hold multOp high 100 cycles → exactly one done.
  - Rise divOp mid-multiply → ignored, mult result correct.
  - Rise multOp and divOp in the same cycle → divide performed.
  - Change A/B during an operation → result reflects the sampled values.
- Reset mid-divide at iteration 10 → next cycle busy=0, done=0, hi=lo=0, divZero=0. No done pulse follows, and a fresh multOp rise works normally.
